// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU encodings, operand-mask positions and ID/EX latch layout
package mips_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SRL   = 4'd3;
    localparam logic [3:0] ALU_SRA   = 4'd4;
    localparam logic [3:0] ALU_AND   = 4'd5;
    localparam logic [3:0] ALU_OR    = 4'd6;
    localparam logic [3:0] ALU_XOR   = 4'd7;
    localparam logic [3:0] ALU_XNOR  = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_SLT   = 4'd10;
    localparam logic [3:0] ALU_ADDM4 = 4'd11;

    localparam int MASK_A_IMM = 1;
    localparam int MASK_B_IMM = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Everything the EX stage keeps about one instruction, apart from its valid bit
    typedef struct packed {
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm1;
        logic [31:0] imm0;
        logic [3:0]  op;
        logic [1:0]  mask;
        logic [4:0]  dst_idx;
        logic        dst_we;
        logic        is_load;
    } ex_regs_t;

    // A producer forwards to a consumer only for a real, non-r0 write to the same register
    function automatic logic fwd_hit(input logic we, input logic [4:0] src_idx, input logic [4:0] dst_idx);
        return we && (src_idx != REG_ZERO) && (src_idx == dst_idx);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks one ALU operand from the EX/MEM result, the MEM/WB result or the captured value
module fwd_mux
    import mips_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
)(
    input  logic [4:0]  i_idx,
    input  logic [31:0] i_val,
    input  logic        i_mem_we,
    input  logic [4:0]  i_mem_idx,
    input  logic [31:0] i_mem_val,
    input  logic        i_mem_is_load,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_idx,
    input  logic [31:0] i_wb_val,
    output logic [31:0] o_val
);

    logic w_mem_hit;
    logic w_wb_hit;

    // A load's EX/MEM value is only an address, so it never forwards; MEM beats WB as the younger write
    always_comb begin
        w_mem_hit = FWD_EN && fwd_hit(i_mem_we && !i_mem_is_load, i_mem_idx, i_idx);
        w_wb_hit  = FWD_EN && fwd_hit(i_wb_we, i_wb_idx, i_idx);
        o_val     = w_mem_hit ? i_mem_val : (w_wb_hit ? i_wb_val : i_val);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding, load-use bubbles, flush and hold
module id_ex_stage
    import mips_pkg::*;
#(
    parameter bit FWD_EN      = 1'b1,
    parameter int STALL_CNT_W = 32
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [4:0]             i_id_rs_idx,
    input  logic [4:0]             i_id_rt_idx,
    input  logic                   i_id_use_rs,
    input  logic                   i_id_use_rt,
    input  logic [31:0]            i_id_rs_val,
    input  logic [31:0]            i_id_rt_val,
    input  logic [31:0]            i_id_imm1,
    input  logic [31:0]            i_id_imm0,
    input  logic [3:0]             i_id_alu_op,
    input  logic [1:0]             i_id_alu_mask,
    input  logic [4:0]             i_id_dst_idx,
    input  logic                   i_id_dst_we,
    input  logic                   i_id_is_load,
    input  logic                   i_flush,
    input  logic                   i_ex_hold,
    input  logic                   i_mem_fwd_we,
    input  logic [4:0]             i_mem_fwd_idx,
    input  logic [31:0]            i_mem_fwd_val,
    input  logic                   i_mem_is_load,
    input  logic                   i_wb_fwd_we,
    input  logic [4:0]             i_wb_fwd_idx,
    input  logic [31:0]            i_wb_fwd_val,
    output logic                   o_ex_valid,
    output logic [31:0]            o_ex_a,
    output logic [31:0]            o_ex_b,
    output logic [31:0]            o_ex_imm1,
    output logic [31:0]            o_ex_imm0,
    output logic [3:0]             o_ex_op,
    output logic [1:0]             o_ex_mask,
    output logic [4:0]             o_ex_dst_idx,
    output logic                   o_ex_dst_we,
    output logic                   o_ex_is_load,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    ex_regs_t               r_ex;
    logic                   r_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    ex_regs_t               w_cap;
    logic                   w_luh;

    // Load-use hazard: the loaded value is not available to the instruction right behind the load
    always_comb begin
        w_luh = r_valid && r_ex.is_load && r_ex.dst_we && (r_ex.dst_idx != REG_ZERO) && i_id_valid &&
                ((i_id_use_rs && (i_id_rs_idx == r_ex.dst_idx)) || (i_id_use_rt && (i_id_rt_idx == r_ex.dst_idx)));
    end

    assign o_id_ready = !i_ex_hold && !w_luh;

    // Capture view of the ID slot; WB forwarding here stands in for a regfile without write-through
    always_comb begin
        w_cap.rs_idx  = i_id_rs_idx;
        w_cap.rt_idx  = i_id_rt_idx;
        w_cap.rs_val  = fwd_hit(i_wb_fwd_we, i_wb_fwd_idx, i_id_rs_idx) ? i_wb_fwd_val : i_id_rs_val;
        w_cap.rt_val  = fwd_hit(i_wb_fwd_we, i_wb_fwd_idx, i_id_rt_idx) ? i_wb_fwd_val : i_id_rt_val;
        w_cap.imm1    = i_id_imm1;
        w_cap.imm0    = i_id_imm0;
        w_cap.op      = i_id_alu_op;
        w_cap.mask    = i_id_alu_mask;
        w_cap.dst_idx = i_id_dst_idx;
        w_cap.dst_we  = i_id_dst_we && i_id_valid;
        w_cap.is_load = i_id_is_load;
    end

    // Stage update in priority order: reset, flush, hold, load-use bubble, normal capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ex        <= '0;
            r_stall_cnt <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ex    <= '0;
        end else if (i_ex_hold) begin
            r_valid <= r_valid;
        end else if (w_luh) begin
            r_valid        <= 1'b0;
            r_ex.dst_we    <= 1'b0;
            r_ex.is_load   <= 1'b0;
            r_stall_cnt    <= (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + STALL_CNT_W'(1);
        end else begin
            r_valid <= i_id_valid;
            r_ex    <= w_cap;
        end
    end

    fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rs (
        .i_idx         (r_ex.rs_idx),
        .i_val         (r_ex.rs_val),
        .i_mem_we      (i_mem_fwd_we),
        .i_mem_idx     (i_mem_fwd_idx),
        .i_mem_val     (i_mem_fwd_val),
        .i_mem_is_load (i_mem_is_load),
        .i_wb_we       (i_wb_fwd_we),
        .i_wb_idx      (i_wb_fwd_idx),
        .i_wb_val      (i_wb_fwd_val),
        .o_val         (o_ex_a)
    );

    fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_rt (
        .i_idx         (r_ex.rt_idx),
        .i_val         (r_ex.rt_val),
        .i_mem_we      (i_mem_fwd_we),
        .i_mem_idx     (i_mem_fwd_idx),
        .i_mem_val     (i_mem_fwd_val),
        .i_mem_is_load (i_mem_is_load),
        .i_wb_we       (i_wb_fwd_we),
        .i_wb_idx      (i_wb_fwd_idx),
        .i_wb_val      (i_wb_fwd_val),
        .o_val         (o_ex_b)
    );

    assign o_ex_valid   = r_valid;
    assign o_ex_imm1    = r_ex.imm1;
    assign o_ex_imm0    = r_ex.imm0;
    assign o_ex_op      = r_ex.op;
    assign o_ex_mask    = r_ex.mask;
    assign o_ex_dst_idx = r_ex.dst_idx;
    assign o_ex_dst_we  = r_ex.dst_we;
    assign o_ex_is_load = r_ex.is_load;
    assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID->EX stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs_idx, id_rt_idx, id_dst_idx;
    logic        id_use_rs, id_use_rt, id_dst_we, id_is_load;
    logic [31:0] id_rs_val, id_rt_val, id_imm1, id_imm0;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_alu_mask;
    logic        flush, ex_hold;
    logic        mem_fwd_we, mem_is_load, wb_fwd_we;
    logic [4:0]  mem_fwd_idx, wb_fwd_idx;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic        ex_valid, ex_dst_we, ex_is_load;
    logic [31:0] ex_a, ex_b, ex_imm1, ex_imm0;
    logic [3:0]  ex_op;
    logic [1:0]  ex_mask;
    logic [4:0]  ex_dst_idx;
    logic [31:0] stall_cnt;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [1:0]  mask;
        logic [31:0] imm1, imm0;
        logic [4:0]  dst;
        logic        we, ld, rdy;
        logic [31:0] st;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_rs_idx(id_rs_idx), .i_id_rt_idx(id_rt_idx),
        .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
        .i_id_rs_val(id_rs_val), .i_id_rt_val(id_rt_val),
        .i_id_imm1(id_imm1), .i_id_imm0(id_imm0),
        .i_id_alu_op(id_alu_op), .i_id_alu_mask(id_alu_mask),
        .i_id_dst_idx(id_dst_idx), .i_id_dst_we(id_dst_we), .i_id_is_load(id_is_load),
        .i_flush(flush), .i_ex_hold(ex_hold),
        .i_mem_fwd_we(mem_fwd_we), .i_mem_fwd_idx(mem_fwd_idx), .i_mem_fwd_val(mem_fwd_val),
        .i_mem_is_load(mem_is_load),
        .i_wb_fwd_we(wb_fwd_we), .i_wb_fwd_idx(wb_fwd_idx), .i_wb_fwd_val(wb_fwd_val),
        .o_ex_valid(ex_valid), .o_ex_a(ex_a), .o_ex_b(ex_b),
        .o_ex_imm1(ex_imm1), .o_ex_imm0(ex_imm0), .o_ex_op(ex_op), .o_ex_mask(ex_mask),
        .o_ex_dst_idx(ex_dst_idx), .o_ex_dst_we(ex_dst_we), .o_ex_is_load(ex_is_load),
        .o_stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL cyc=%0d %s: got 0x%0h expected 0x%0h", c, name, act, exp);
    endtask

    // Monitor: at each falling edge compare every expectation scheduled for the current cycle
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                $display("FAIL stale expectation: got cycle %0d expected cycle %0d", cyc, e.cyc);
            end else begin
                chk("ex_valid",   e.cyc, {31'd0, ex_valid},   {31'd0, e.valid});
                chk("ex_a",       e.cyc, ex_a,                e.a);
                chk("ex_b",       e.cyc, ex_b,                e.b);
                chk("ex_op",      e.cyc, {28'd0, ex_op},      {28'd0, e.op});
                chk("ex_mask",    e.cyc, {30'd0, ex_mask},    {30'd0, e.mask});
                chk("ex_imm1",    e.cyc, ex_imm1,             e.imm1);
                chk("ex_imm0",    e.cyc, ex_imm0,             e.imm0);
                chk("ex_dst_idx", e.cyc, {27'd0, ex_dst_idx}, {27'd0, e.dst});
                chk("ex_dst_we",  e.cyc, {31'd0, ex_dst_we},  {31'd0, e.we});
                chk("ex_is_load", e.cyc, {31'd0, ex_is_load}, {31'd0, e.ld});
                chk("id_ready",   e.cyc, {31'd0, id_ready},   {31'd0, e.rdy});
                chk("stall_cnt",  e.cyc, stall_cnt,           e.st);
            end
        end
    end

    task automatic expect_out(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                              input logic [1:0] mask, input logic [31:0] imm1, input logic [31:0] imm0,
                              input logic [4:0] dst, input logic we, input logic ld, input logic rdy,
                              input logic [31:0] st);
        exp_t e;
        e.cyc = cyc; e.valid = v; e.a = a; e.b = b; e.op = op; e.mask = mask;
        e.imm1 = imm1; e.imm0 = imm0; e.dst = dst; e.we = we; e.ld = ld; e.rdy = rdy; e.st = st;
        q.push_back(e);
    endtask

    task automatic id_drive(input logic v, input logic [4:0] rs, input logic [31:0] rsv, input logic urs,
                            input logic [4:0] rt, input logic [31:0] rtv, input logic urt,
                            input logic [3:0] op, input logic [1:0] mask, input logic [31:0] imm1,
                            input logic [31:0] imm0, input logic [4:0] dst, input logic we, input logic ld);
        id_valid = v; id_rs_idx = rs; id_rs_val = rsv; id_use_rs = urs;
        id_rt_idx = rt; id_rt_val = rtv; id_use_rt = urt;
        id_alu_op = op; id_alu_mask = mask; id_imm1 = imm1; id_imm0 = imm0;
        id_dst_idx = dst; id_dst_we = we; id_is_load = ld;
    endtask

    task automatic fwd(input logic mwe, input logic [4:0] midx, input logic [31:0] mval, input logic mld,
                       input logic wwe, input logic [4:0] widx, input logic [31:0] wval);
        mem_fwd_we = mwe; mem_fwd_idx = midx; mem_fwd_val = mval; mem_is_load = mld;
        wb_fwd_we = wwe; wb_fwd_idx = widx; wb_fwd_val = wval;
    endtask

    task automatic idle();  id_drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic add1();  id_drive(1, 1, 32'h5, 1, 2, 32'h7, 1, 4'd0, 2'b01, 32'h5, 32'h1234, 3, 1, 0); endtask
    task automatic load4(); id_drive(1, 1, 32'h100, 1, 4, 32'h0, 0, 4'd0, 2'b00, 0, 0, 4, 1, 1); endtask
    task automatic dep4();  id_drive(1, 2, 32'h2, 1, 4, 32'h999, 1, 4'd0, 2'b00, 0, 0, 7, 1, 0); endtask
    task automatic tick();  @(posedge clk); #1; endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        idle(); fwd(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // ADD presented; nothing latched yet
        tick(); rst_n = 1'b1; add1();
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // ADD in EX; second instruction rs=3/rt=5 presented
        tick(); id_drive(1, 3, 32'h11, 1, 5, 32'h22, 1, 4'd1, 2'b00, 0, 0, 6, 1, 0);
        expect_out(1, 5, 7, 0, 2'b01, 32'h5, 32'h1234, 3, 1, 0, 1, 0);
        // Hold instr2 in EX while sweeping the forwarding sources
        tick(); idle(); ex_hold = 1'b1; fwd(1, 3, 32'hAA, 0, 1, 3, 32'hBB);
        expect_out(1, 32'hAA, 32'h22, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); fwd(0, 3, 32'hAA, 0, 1, 3, 32'hBB);
        expect_out(1, 32'hBB, 32'h22, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); fwd(1, 3, 32'hAA, 1, 1, 3, 32'hBB);
        expect_out(1, 32'hBB, 32'h22, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); fwd(1, 0, 32'hAA, 0, 1, 0, 32'hBB);
        expect_out(1, 32'h11, 32'h22, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        tick(); fwd(0, 0, 0, 0, 1, 5, 32'hCC);
        expect_out(1, 32'h11, 32'hCC, 1, 0, 0, 0, 6, 1, 0, 0, 0);
        // Release hold, present load r4
        tick(); ex_hold = 1'b0; fwd(0, 0, 0, 0, 0, 0, 0); load4();
        expect_out(1, 32'h11, 32'h22, 1, 0, 0, 0, 6, 1, 0, 1, 0);
        // Load in EX, dependent in ID reads r4 via rt -> hazard
        tick(); dep4();
        expect_out(1, 32'h100, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        // Bubble; load now in MEM (its address must not forward)
        tick(); fwd(1, 4, 32'hDEAD, 1, 0, 0, 0);
        expect_out(0, 32'h100, 0, 0, 0, 0, 0, 4, 0, 0, 1, 1);
        // Dependent in EX, load data arrives through WB
        tick(); idle(); fwd(0, 0, 0, 0, 1, 4, 32'h444);
        expect_out(1, 32'h2, 32'h444, 0, 0, 0, 0, 7, 1, 0, 1, 1);
        // rt=4 but not used: no stall
        tick(); fwd(0, 0, 0, 0, 0, 0, 0); load4();
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick(); id_drive(1, 1, 32'h33, 1, 4, 32'h44, 0, 4'd0, 2'b00, 0, 0, 8, 1, 0);
        expect_out(1, 32'h100, 0, 0, 0, 0, 0, 4, 1, 1, 1, 1);
        // Flush coinciding with a load-use hazard
        tick(); load4();
        expect_out(1, 32'h33, 32'h44, 0, 0, 0, 0, 8, 1, 0, 1, 1);
        tick(); dep4(); flush = 1'b1;
        expect_out(1, 32'h100, 0, 0, 0, 0, 0, 4, 1, 1, 0, 1);
        tick(); flush = 1'b0; idle();
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // ADD captured with WB value replacing the stale regfile read of r1
        tick(); add1(); fwd(0, 0, 0, 0, 1, 1, 32'h55);
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Hold three cycles with changing ID, reset during the hold
        tick(); fwd(0, 0, 0, 0, 0, 0, 0); ex_hold = 1'b1;
        id_drive(1, 9, 32'h99, 1, 10, 32'h1010, 1, 4'd7, 2'b10, 32'h9, 32'h9, 11, 1, 0);
        expect_out(1, 32'h55, 7, 0, 2'b01, 32'h5, 32'h1234, 3, 1, 0, 0, 1);
        tick(); id_drive(1, 12, 32'h77, 1, 13, 32'h78, 1, 4'd6, 2'b11, 32'h1, 32'h2, 14, 1, 1);
        expect_out(1, 32'h55, 7, 0, 2'b01, 32'h5, 32'h1234, 3, 1, 0, 0, 1);
        tick(); id_drive(1, 15, 32'h66, 1, 16, 32'h67, 1, 4'd5, 2'b00, 32'h3, 32'h4, 17, 1, 0); rst_n = 1'b0;
        expect_out(1, 32'h55, 7, 0, 2'b01, 32'h5, 32'h1234, 3, 1, 0, 0, 1);
        tick(); rst_n = 1'b1; ex_hold = 1'b0; idle();
        expect_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
